sme_rng_src: RTL and testbench

- Randomness source feeding the `rng[RM:0]` guard-share bus consumed by the SME ALU, masked AND and masked adder.
- Loads RMAX seed words over a valid/ready seeding handshake from the core's entropy/CSR path.
- Then advances RMAX independent 32-bit Galois LFSR lanes, one step per consumer request.
- Sits beside the SME ALU and drives its `rng` input directly.

---
 rtl/sme_rng_src.sv | 111 +++++++++++
 tb/tb_sme_rng_src.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sme_rng_src.sv
// sme_rng_src: seeded bank of RMAX 32-bit Galois LFSR lanes driving the SME guard-share rng bus.
// Build macro SME_RNG_HEALTH_EN adds a sticky zero-lane health_err output that masks rng_ok.
module sme_rng_src #(
    parameter  int XLEN = 32,
    parameter  int SMAX = 4,
    localparam int RMAX = SMAX + SMAX*(SMAX-1)/2,
    localparam int RM   = RMAX - 1,
    localparam int IW   = (RMAX > 1) ? $clog2(RMAX) : 1
)(
    input  logic            g_clk,
    input  logic            g_reset,
    output logic            g_clk_req,
    input  logic            seed_valid,
    output logic            seed_ready,
    input  logic [XLEN-1:0] seed_data,
    input  logic            step,
    output logic [XLEN-1:0] rng [RM:0],
    output logic            rng_ok,
`ifdef SME_RNG_HEALTH_EN
    output logic            health_err,
`endif
    output logic [IW-1:0]   seed_idx
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("sme_rng_src supports XLEN=32 only");
    end

    typedef enum logic [1:0] {UNSEEDED, SEEDING, RUN} state_t;

    state_t          r_state, w_nstate;
    logic [XLEN-1:0] r_lane [RM:0];
    logic [XLEN-1:0] w_next [RM:0];
    logic [IW-1:0]   r_idx;
    logic [XLEN-1:0] w_seed;
    logic            w_last;

    assign w_last = (r_idx == IW'(RM));
    // A zero seed would lock its lane at zero forever, so substitute a lane-unique constant.
    assign w_seed = (seed_data != '0) ? seed_data : 32'hACE10000 ^ (XLEN'(r_idx) + XLEN'(1));

    for (genvar k = 0; k < RMAX; k++) begin : g_lane
        assign w_next[k] = r_lane[k][0] ? (r_lane[k] >> 1) ^ 32'h80200003 : r_lane[k] >> 1;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset)
            r_state <= UNSEEDED;
        else
            r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            UNSEEDED: w_nstate = seed_valid ? SEEDING : UNSEEDED;
            SEEDING:  w_nstate = (seed_valid && w_last) ? RUN : SEEDING;
            RUN:      w_nstate = seed_valid ? SEEDING : RUN;
            default:  w_nstate = UNSEEDED;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            for (int i = 0; i < RMAX; i++) r_lane[i] <= '0;
            r_idx <= '0;
        end else if (r_state == SEEDING) begin
            if (seed_valid) begin
                r_lane[r_idx] <= w_seed;
                r_idx         <= w_last ? '0 : r_idx + IW'(1);
            end
        end else if (r_state == RUN) begin
            if (step) for (int i = 0; i < RMAX; i++) r_lane[i] <= w_next[i];
            if (seed_valid) r_idx <= '0;
        end
    end

`ifdef SME_RNG_HEALTH_EN
    logic r_health;
    logic w_zero;

    always_comb begin
        w_zero = 1'b0;
        for (int i = 0; i < RMAX; i++) if (r_lane[i] == '0) w_zero = 1'b1;
    end

    // Sticky until the next seeding pass starts; only RUN lanes are expected to be nonzero.
    always_ff @(posedge g_clk) begin
        if (g_reset)
            r_health <= 1'b0;
        else
            r_health <= (w_nstate == SEEDING) ? 1'b0 : (r_health || (r_state == RUN && w_zero));
    end

    assign health_err = r_health;
`endif

    always_comb begin
        seed_ready = (r_state == SEEDING);
        g_clk_req  = (r_state == SEEDING) || step;
`ifdef SME_RNG_HEALTH_EN
        rng_ok     = (r_state == RUN) && !r_health;
`else
        rng_ok     = (r_state == RUN);
`endif
    end

    assign rng      = r_lane;
    assign seed_idx = r_idx;

endmodule

// File: tb/tb_sme_rng_src.sv
// tb_sme_rng_src: directed seeding/stepping/reseed/reset sequences with queued expectations
// checked by an independent monitor on the falling clock edge.
module tb_sme_rng_src;

    logic        clk;
    logic        g_reset;
    logic        g_clk_req;
    logic        seed_valid;
    logic        seed_ready;
    logic [31:0] seed_data;
    logic        step;
    logic [31:0] rng [9:0];
    logic        rng_ok;
    logic [3:0]  seed_idx;

    sme_rng_src dut (
        .g_clk      (clk),
        .g_reset    (g_reset),
        .g_clk_req  (g_clk_req),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed_data  (seed_data),
        .step       (step),
        .rng        (rng),
        .rng_ok     (rng_ok),
        .seed_idx   (seed_idx)
    );

    localparam int OK = 10, RDY = 11, IDX = 12, CREQ = 13;

    typedef struct {
        string       nm;
        int          k;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_v(input string nm, input int k, input logic [31:0] v);
        q.push_back('{nm, k, v});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic seed_word(input logic [31:0] d);
        seed_valid = 1'b1;
        seed_data  = d;
        tick;
    endtask

    // Monitor: drains every queued expectation against the settled DUT outputs.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e   = q.pop_front();
            act = (e.k < 10)   ? rng[e.k] :
                  (e.k == OK)  ? {31'b0, rng_ok} :
                  (e.k == RDY) ? {31'b0, seed_ready} :
                  (e.k == IDX) ? {28'b0, seed_idx} : {31'b0, g_clk_req};
            checks++;
            if (act !== e.v) begin
                errs++;
                $display("FAIL %s: got %h want %h", e.nm, act, e.v);
            end
        end
    end

    initial begin
        g_reset    = 1'b1;
        seed_valid = 1'b0;
        seed_data  = '0;
        step       = 1'b0;
        tick;
        tick;
        g_reset = 1'b0;
        expect_v("rst_ok", OK, 0);
        expect_v("rst_rdy", RDY, 0);
        expect_v("rst_idx", IDX, 0);
        expect_v("rst_lane0", 0, 0);
        expect_v("rst_lane9", 9, 0);
        expect_v("unseeded_creq", CREQ, 0);

        // First valid only moves to SEEDING; the word is not consumed.
        seed_word(32'h0000_0077);
        expect_v("enter_seed_rdy", RDY, 1);
        expect_v("enter_seed_lane0", 0, 0);
        expect_v("enter_seed_idx", IDX, 0);
        expect_v("seeding_creq", CREQ, 1);
        for (int i = 0; i < 10; i++) begin
            seed_word(32'(i + 1));
            if (i == 8) expect_v("ok_before_last", OK, 0);
        end
        seed_valid = 1'b0;
        expect_v("run_ok", OK, 1);
        expect_v("run_rdy", RDY, 0);
        expect_v("run_idx_wrap", IDX, 0);
        expect_v("seed_lane0", 0, 32'h1);
        expect_v("seed_lane9", 9, 32'hA);

        step = 1'b1;
        #1;
        expect_v("run_creq_step", CREQ, 1);
        tick;
        expect_v("step1_lane0", 0, 32'h8020_0003);
        expect_v("step1_lane1", 1, 32'h1);
        expect_v("step1_lane9", 9, 32'h5);
        tick;
        expect_v("step2_lane0", 0, 32'hC030_0002);
        expect_v("step2_lane1", 1, 32'h8020_0003);
        expect_v("step2_lane9", 9, 32'h8020_0001);
        step = 1'b0;
        #1;
        expect_v("run_creq_idle", CREQ, 0);
        tick;
        expect_v("hold_lane0", 0, 32'hC030_0002);

        // Reseed request together with step: step still applied.
        step = 1'b1;
        seed_word(32'h0000_0099);
        expect_v("reseed_ok", OK, 0);
        expect_v("reseed_rdy", RDY, 1);
        expect_v("reseed_step_lane0", 0, 32'h6018_0001);
        expect_v("reseed_step_lane1", 1, 32'hC030_0002);
        seed_word(32'h11);
        expect_v("reseed_lane0", 0, 32'h11);
        expect_v("step_ignored_lane1", 1, 32'hC030_0002);
        seed_word(32'h22);
        seed_word(32'h0);
        expect_v("zero_seed_lane2", 2, 32'hACE1_0003);
        seed_word(32'h44);
        seed_word(32'h55);
        expect_v("five_idx", IDX, 5);

        // Reset mid-seeding dominates a live seed_valid.
        g_reset = 1'b1;
        tick;
        g_reset    = 1'b0;
        seed_valid = 1'b0;
        step       = 1'b0;
        expect_v("midrst_ok", OK, 0);
        expect_v("midrst_rdy", RDY, 0);
        expect_v("midrst_idx", IDX, 0);
        expect_v("midrst_lane0", 0, 0);
        expect_v("midrst_lane2", 2, 0);

        step = 1'b1;
        seed_word(32'h0);
        for (int i = 0; i < 10; i++) seed_word((i == 2) ? 32'h0 : 32'hA0 + 32'(i));
        seed_valid = 1'b0;
        expect_v("reseed2_ok", OK, 1);
        expect_v("reseed2_lane0", 0, 32'hA0);
        expect_v("reseed2_lane2", 2, 32'hACE1_0003);
        expect_v("reseed2_lane9", 9, 32'hA9);

        seed_word(32'h1);
        step = 1'b0;
        expect_v("reseed3_ok", OK, 0);
        expect_v("reseed3_lane0", 0, 32'h50);
        expect_v("reseed3_lane2", 2, 32'hD650_8002);
        for (int i = 0; i < 10; i++) seed_word(32'h1000 + 32'(i));
        seed_valid = 1'b0;
        expect_v("reseed3_done_ok", OK, 1);
        expect_v("reseed3_lane9", 9, 32'h1009);
        tick;
        expect_v("final_hold_lane9", 9, 32'h1009);
        expect_v("final_creq", CREQ, 0);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
